// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the binary seven-segment display.
//   SEG_BLANK / SEG_DASH : active-low segment patterns {g,f,e,d,c,b,a}
//   state_e              : conversion FSM states
//   digit_to_seg()       : BCD nibble -> active-low segments (10..15 -> blank)
//   pow10()              : 10^n, used to size the overflow limit at elaboration
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_bin_display_if.sv
// seg7_bin_display_if -- load handshake and display outputs of seg7_bin_display.
//   load_i     : request a conversion of bin_i
//   bin_i      : unsigned value to display
//   blank_lz_i : blank leading zeros (sampled with load_i)
//   blink_i    : blink the whole display (live)
//   busy_o     : conversion in progress
//   done_o     : one-cycle pulse when new segments are committed
//   ovf_o      : last committed value did not fit in DIGITS digits
//   seg_o      : DIGITS x 7 segment bits, seg_o[6:0] = least significant digit
// master = the block driving requests, slave = the display block.
interface seg7_bin_display_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  load_i;
  logic [BIN_W-1:0]      bin_i;
  logic                  blank_lz_i;
  logic                  blink_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ovf_o;
  logic [7*DIGITS-1:0]   seg_o;

  modport master (
    output load_i, bin_i, blank_lz_i, blink_i,
    input  busy_o, done_o, ovf_o, seg_o
  );

  modport slave (
    input  load_i, bin_i, blank_lz_i, blink_i,
    output busy_o, done_o, ovf_o, seg_o
  );
endinterface

// File: rtl/seg7_digit_enc.sv
// seg7_digit_enc -- combinational encoder for one display digit.
//   nibble_i : BCD digit value
//   blank_i  : force the digit dark
//   dash_i   : show a dash (overflow); wins over blank_i
//   seg_o    : active-low segments {g,f,e,d,c,b,a}
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = digit_to_seg(nibble_i);
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_bin_display.sv
// seg7_bin_display -- binary to multi-digit seven-segment display driver.
// A load captures an unsigned value, a double-dabble engine converts it to
// BCD one bit per clock, and the result is committed to registered digits
// with optional leading-zero blanking or an all-dash overflow pattern.
// A free-running counter provides a blink phase gating the whole display.
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   bus     : seg7_bin_display_if slave (load/bin/blank_lz/blink in,
//             busy/done/ovf/seg out)
module seg7_bin_display
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int BIN_W      = 14,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  seg7_bin_display_if.slave   bus
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int SR_W    = BCD_W + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Largest displayable value. When every BIN_W-bit input fits, overflow
  // can never happen and the limit is not needed.
  localparam longint unsigned LIMIT_FULL = pow10(DIGITS) - 64'd1;
  localparam bit              CAN_OVF    = LIMIT_FULL < ((64'd1 << BIN_W) - 64'd1);
  localparam logic [BIN_W:0]  OVF_LIMIT  = CAN_OVF ? (BIN_W+1)'(LIMIT_FULL) : '1;

  state_e                state_q;
  logic [SR_W-1:0]       sr_q;          // {bcd accumulator, binary shift reg}
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  ovf_pend_q;
  logic                  blank_lz_q;
  logic [7*DIGITS-1:0]   seg_q;         // committed digits, active-low

  logic [BLINK_W-1:0]    blink_cnt_q;
  logic                  blink_ph_q;

  logic [BCD_W-1:0]      adj_bcd;
  logic [SR_W-1:0]       sr_d;
  logic [7*DIGITS-1:0]   enc_seg;
  logic                  ovf_in;
  logic [7*DIGITS-1:0]   seg_disp;

  assign ovf_in = CAN_OVF && ({1'b0, bus.bin_i} > OVF_LIMIT);

  // ---------------------------------------------------------------------------
  // Double-dabble step: add 3 to every nibble >= 5, then shift left by one.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      logic [3:0] nib;
      assign nib = sr_q[BIN_W + 4*gi +: 4];
      assign adj_bcd[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  assign sr_d = {adj_bcd, sr_q[BIN_W-1:0]} << 1;

  // ---------------------------------------------------------------------------
  // Digit encoders work on the post-shift BCD so the last shift and the commit
  // happen on the same edge. zero_from[i] is set when digits i..DIGITS-1 are
  // all zero; digit 0 is never blanked so a zero value still shows "0".
  // ---------------------------------------------------------------------------
  logic [DIGITS:1] zero_from;
  assign zero_from[DIGITS] = 1'b1;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_enc
      logic [3:0] fin_nib;
      logic       blank;
      assign fin_nib = sr_d[BIN_W + 4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign blank = 1'b0;
      end else begin : g_upper
        assign zero_from[gi] = zero_from[gi+1] & (fin_nib == 4'd0);
        assign blank         = blank_lz_q & zero_from[gi];
      end
      seg7_digit_enc u_enc (
        .nibble_i (fin_nib),
        .blank_i  (blank),
        .dash_i   (ovf_pend_q),
        .seg_o    (enc_seg[7*gi +: 7])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Conversion FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      blank_lz_q <= 1'b0;
      seg_q      <= {DIGITS{SEG_BLANK}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.load_i) begin
            sr_q       <= {{BCD_W{1'b0}}, bus.bin_i};
            cnt_q      <= '0;
            blank_lz_q <= bus.blank_lz_i;
            ovf_pend_q <= ovf_in;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ovf_q   <= ovf_pend_q;
            seg_q   <= enc_seg;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timebase: free-running, independent of blink_i.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= ~blink_ph_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Blink gating leaves seg_q untouched so the value returns on phase 0;
  // polarity inversion is the final stage.
  always_comb begin
    seg_disp = seg_q;
    if (bus.blink_i && blink_ph_q) begin
      seg_disp = {DIGITS{SEG_BLANK}};
    end
  end

  assign bus.seg_o  = (ACTIVE_LOW != 0) ? seg_disp : ~seg_disp;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
module tb_seg7_bin_display;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int BDIV   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_bin_display_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  seg7_bin_display #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .BLINK_DIV(BDIV), .ACTIVE_LOW(1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0011000,
                         SB = 7'b1111111, SD = 7'b0111111;

  typedef struct {
    logic [13:0] bin;
    logic        lz;
    logic [27:0] seg;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
  } exp_t;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int txn = 0;
  exp_t sb[$];
  vec_t vecs[13];

  // Reference blink phase: counts 0..BDIV-1 on every enabled clock.
  int ref_bcnt;
  bit ref_ph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_bcnt <= 0;
      ref_ph   <= 1'b0;
    end else if (ref_bcnt == BDIV - 1) begin
      ref_bcnt <= 0;
      ref_ph   <= ~ref_ph;
    end else begin
      ref_bcnt <= ref_bcnt + 1;
    end
  end

  function automatic logic [27:0] mk4(input logic [6:0] d3, input logic [6:0] d2,
                                      input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mkv(input int b, input logic lz, input logic [27:0] s, input logic o);
    vec_t v;
    v.bin = 14'(b);
    v.lz  = lz;
    v.seg = s;
    v.ovf = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard consumer: every done_o pulse pops one expected commit.
  always @(negedge clk) begin
    if (rst_n && bus.done_o === 1'b1) begin
      done_cnt++;
      txn++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %0d: seg=%07h ovf=%b (expected seg=%07h ovf=%b)",
                 txn, bus.seg_o, bus.ovf_o, e.seg, e.ovf);
        check("commit_seg", 64'(bus.seg_o), 64'(e.seg));
        check("commit_ovf", 64'(bus.ovf_o), 64'(e.ovf));
      end
    end
  end

  // Must be called at a negedge; leaves at the negedge after the accepting edge.
  task automatic start_load(input logic [13:0] b, input logic lz,
                            input logic [27:0] s, input logic o);
    exp_t e;
    bus.load_i     = 1'b1;
    bus.bin_i      = b;
    bus.blank_lz_i = lz;
    e.seg = s;
    e.ovf = o;
    sb.push_back(e);
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  // Counts busy cycles from now until busy drops; ends at the done_o negedge.
  task automatic wait_done(input int exp_busy);
    int n = 0;
    while (bus.busy_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 64'(n), 64'(exp_busy));
    check("done_pulse", 64'(bus.done_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    bus.load_i = 1'b0;
    bus.bin_i = '0;
    bus.blank_lz_i = 1'b0;
    bus.blink_i = 1'b0;

    vecs[0]  = mkv(1234,  1'b0, mk4(S1, S2, S3, S4), 1'b0);
    vecs[1]  = mkv(7,     1'b1, mk4(SB, SB, SB, S7), 1'b0);
    vecs[2]  = mkv(0,     1'b1, mk4(SB, SB, SB, S0), 1'b0);
    vecs[3]  = mkv(10000, 1'b0, mk4(SD, SD, SD, SD), 1'b1);
    vecs[4]  = mkv(9999,  1'b0, mk4(S9, S9, S9, S9), 1'b0);
    vecs[5]  = mkv(42,    1'b1, mk4(SB, SB, S4, S2), 1'b0);
    vecs[6]  = mkv(42,    1'b0, mk4(S0, S0, S4, S2), 1'b0);
    vecs[7]  = mkv(16383, 1'b1, mk4(SD, SD, SD, SD), 1'b1);
    vecs[8]  = mkv(1005,  1'b1, mk4(S1, S0, S0, S5), 1'b0);
    vecs[9]  = mkv(0,     1'b0, mk4(S0, S0, S0, S0), 1'b0);
    vecs[10] = mkv(80,    1'b1, mk4(SB, SB, S8, S0), 1'b0);
    vecs[11] = mkv(9000,  1'b1, mk4(S9, S0, S0, S0), 1'b0);
    vecs[12] = mkv(5555,  1'b0, mk4(S5, S5, S5, S5), 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_ovf",  64'(bus.ovf_o),  64'd0);
    check("rst_seg",  64'(bus.seg_o),  64'hFFFFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven conversions
    for (int i = 0; i < 13; i++) begin
      start_load(vecs[i].bin, vecs[i].lz, vecs[i].seg, vecs[i].ovf);
      wait_done(BIN_W);
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done_o), 64'd0);
    end

    // Load during busy is ignored
    d0 = done_cnt;
    start_load(14'd42, 1'b0, mk4(S0, S0, S4, S2), 1'b0);
    repeat (3) @(negedge clk);
    bus.load_i = 1'b1;
    bus.bin_i  = 14'd99;
    @(negedge clk);
    bus.load_i = 1'b0;
    wait_done(10);
    repeat (20) @(negedge clk);
    check("ignored_load_dones", 64'(done_cnt - d0), 64'd1);
    check("ignored_load_seg", 64'(bus.seg_o), 64'(mk4(S0, S0, S4, S2)));

    // Load in the done_o cycle is accepted
    start_load(14'd1234, 1'b1, mk4(S1, S2, S3, S4), 1'b0);
    wait_done(BIN_W);
    start_load(14'd7, 1'b0, mk4(S0, S0, S0, S7), 1'b0);
    wait_done(BIN_W);
    @(negedge clk);

    // Blink with 5555 shown
    start_load(14'd5555, 1'b0, mk4(S5, S5, S5, S5), 1'b0);
    wait_done(BIN_W);
    bus.blink_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("blink_on", 64'(bus.seg_o),
            ref_ph ? 64'hFFFFFFF : 64'(mk4(S5, S5, S5, S5)));
    end
    bus.blink_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("blink_off", 64'(bus.seg_o), 64'(mk4(S5, S5, S5, S5)));
    end

    // Reset mid-conversion after an overflow commit
    start_load(14'd16383, 1'b0, mk4(SD, SD, SD, SD), 1'b1);
    wait_done(BIN_W);
    @(negedge clk);
    start_load(14'd1234, 1'b0, mk4(S1, S2, S3, S4), 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("midrst_seg",  64'(bus.seg_o),  64'hFFFFFFF);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_ovf",  64'(bus.ovf_o),  64'd0);
    check("midrst_done", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    check("midrst_idle_busy", 64'(bus.busy_o), 64'd0);
    start_load(14'd9000, 1'b1, mk4(S9, S0, S0, S0), 1'b0);
    wait_done(BIN_W);
    @(negedge clk);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
